// File: rtl/turn_signal_recorder_pkg.sv
// ============================================================================
// Module   : turn_signal_pkg
// Brief    : Shared turn-signal encodings, RAM word layout and recorder FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package turn_signal_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_HAZARD = 2'b01;
  localparam logic [1:0] ST_TURN   = 2'b10;
  localparam logic [1:0] END_MARK  = 2'b11;

  // Word layout, MSB first: {state[1:0], lr, dur[DUR_W-1:0]}
  localparam int STATE_W = 2;
  localparam int LR_W    = 1;
  localparam int HDR_W   = STATE_W + LR_W;

  typedef enum logic [2:0] {
    REC_IDLE   = 3'd0,
    REC_RECORD = 3'd1,
    REC_FLUSH  = 3'd2,
    REC_TERM   = 3'd3,
    REC_DONE   = 3'd4
  } rec_state_e;

  // Live data may never alias the end marker.
  function automatic logic [1:0] coerce_state(input logic [1:0] s);
    return (s == END_MARK) ? ST_IDLE : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/turn_signal_recorder.sv
// ============================================================================
// Module   : turn_signal_recorder
// Brief    : Run-length encodes live turn-signal state into an external RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_signal_recorder
  import turn_signal_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DUR_W  = 5
) (
  input  logic                   memoryClock,
  input  logic                   reset_n,
  input  logic                   rec_start,
  input  logic                   rec_stop,
  input  logic [1:0]             state_in,
  input  logic                   lr_in,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [HDR_W+DUR_W-1:0] wr_data,
  output logic                   busy,
  output logic                   full,
  output logic                   done,
  output logic [ADDR_W:0]        entry_count
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
  localparam logic [ADDR_W-1:0] FULL_ADDR = ADDR_W'(DEPTH - 2);

  rec_state_e              r_state, w_state_nx;
  logic [HDR_W-1:0]        r_cur, w_cur_nx;
  logic [DUR_W-1:0]        r_dur, w_dur_nx;
  logic [ADDR_W-1:0]       r_addr, w_addr_nx;
  logic                    r_wr_en, w_wr_en_nx;
  logic [ADDR_W-1:0]       r_wr_addr, w_wr_addr_nx;
  logic [HDR_W+DUR_W-1:0]  r_wr_data, w_wr_data_nx;
  logic                    r_full, w_full_nx;
  logic                    r_busy, w_busy_nx;
  logic                    r_done, w_done_nx;
  logic [ADDR_W:0]         r_entry_count, w_entry_count_nx;
  logic [HDR_W-1:0]        w_sample;
  logic [ADDR_W-1:0]       w_addr_inc;

  assign w_sample   = {coerce_state(state_in), lr_in};
  assign w_addr_inc = r_addr + ADDR_W'(1);

  always_ff @(posedge memoryClock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= REC_IDLE;
      r_cur         <= '0;
      r_dur         <= '0;
      r_addr        <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_full        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_entry_count <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_cur         <= w_cur_nx;
      r_dur         <= w_dur_nx;
      r_addr        <= w_addr_nx;
      r_wr_en       <= w_wr_en_nx;
      r_wr_addr     <= w_wr_addr_nx;
      r_wr_data     <= w_wr_data_nx;
      r_full        <= w_full_nx;
      r_busy        <= w_busy_nx;
      r_done        <= w_done_nx;
      r_entry_count <= w_entry_count_nx;
    end
  end

  always_comb begin
    w_state_nx       = r_state;
    w_cur_nx         = r_cur;
    w_dur_nx         = r_dur;
    w_addr_nx        = r_addr;
    w_wr_en_nx       = 1'b0;
    w_wr_addr_nx     = r_wr_addr;
    w_wr_data_nx     = r_wr_data;
    w_full_nx        = r_full;
    w_entry_count_nx = r_entry_count;
    // busy/done reflect the state held during the cycle just ended, so done
    // rises only once the marker has been committed by the RAM.
    w_busy_nx        = (r_state == REC_RECORD) || (r_state == REC_FLUSH) ||
                       (r_state == REC_TERM);
    w_done_nx        = (r_state == REC_DONE);

    case (r_state)
      REC_IDLE, REC_DONE: begin
        if (rec_start) begin
          w_cur_nx         = w_sample;
          w_dur_nx         = DUR_W'(1);
          w_addr_nx        = '0;
          w_full_nx        = 1'b0;
          w_entry_count_nx = '0;
          w_state_nx       = REC_RECORD;
        end
      end
      REC_RECORD: begin
        if (rec_stop) begin
          w_state_nx = REC_FLUSH;
        end else if ((w_sample != r_cur) || (r_dur == DUR_MAX)) begin
          w_wr_en_nx   = 1'b1;
          w_wr_addr_nx = r_addr;
          w_wr_data_nx = {r_cur, r_dur};
          w_addr_nx    = w_addr_inc;
          w_cur_nx     = w_sample;
          w_dur_nx     = DUR_W'(1);
          // Reserve the last two slots for the flush word and the marker.
          if (w_addr_inc == FULL_ADDR) begin
            w_full_nx  = 1'b1;
            w_state_nx = REC_FLUSH;
          end
        end else begin
          w_dur_nx = r_dur + DUR_W'(1);
        end
      end
      REC_FLUSH: begin
        w_wr_en_nx   = 1'b1;
        w_wr_addr_nx = r_addr;
        w_wr_data_nx = {r_cur, r_dur};
        w_addr_nx    = w_addr_inc;
        w_state_nx   = REC_TERM;
      end
      REC_TERM: begin
        w_wr_en_nx       = 1'b1;
        w_wr_addr_nx     = r_addr;
        w_wr_data_nx     = {END_MARK, 1'b0, {DUR_W{1'b0}}};
        w_entry_count_nx = {1'b0, r_addr} + (ADDR_W+1)'(1);
        w_state_nx       = REC_DONE;
      end
      default: w_state_nx = REC_IDLE;
    endcase
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = r_busy;
  assign full        = r_full;
  assign done        = r_done;
  assign entry_count = r_entry_count;

endmodule

`default_nettype wire

// File: tb/tb_turn_signal_recorder.sv
// ============================================================================
// Module   : tb_turn_signal_recorder
// Brief    : Directed self-checking bench for turn_signal_recorder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_turn_signal_recorder;
  import turn_signal_pkg::*;

  logic       memoryClock;
  logic       reset_n;
  logic       rec_start;
  logic       rec_stop;
  logic [1:0] state_in;
  logic       lr_in;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       full;
  logic       done;
  logic [4:0] entry_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int w0;
  logic [7:0] ram [16];

  turn_signal_recorder #(.ADDR_W(4), .DUR_W(5)) dut (
    .memoryClock (memoryClock),
    .reset_n     (reset_n),
    .rec_start   (rec_start),
    .rec_stop    (rec_stop),
    .state_in    (state_in),
    .lr_in       (lr_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .full        (full),
    .done        (done),
    .entry_count (entry_count)
  );

  initial begin
    memoryClock = 1'b0;
    forever #5 memoryClock = ~memoryClock;
  end

  // External RAM model: commits the bus word on the next edge.
  always @(posedge memoryClock) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
      n_wr         <= n_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge memoryClock);
    #1;
  endtask

  task automatic start_rec(input logic [1:0] st, input logic lr);
    state_in  = st;
    lr_in     = lr;
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
  endtask

  // Stop edge plus FLUSH, TERM and the DONE-entry edge.
  task automatic stop_and_finish();
    rec_stop = 1'b1;
    step();
    rec_stop = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    rec_start = 1'b1;
    rec_stop  = 1'b1;
    state_in  = 2'b10;
    lr_in     = 1'b1;

    // Reset held with active inputs
    for (int i = 0; i < 3; i++) step();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_entry", 32'(entry_count), 32'd0);
    chk("rst_no_writes", 32'(n_wr), 32'd0);
    rec_start = 1'b0;
    rec_stop  = 1'b0;
    #2 reset_n = 1'b1;
    step();

    // HAZARD/lr0 x3, IDLE x2, stop
    w0 = n_wr;
    start_rec(2'b01, 1'b0);
    chk("t1_no_wr_at_start", 32'(wr_en), 32'd0);
    step();
    step();
    state_in = 2'b00;
    step();
    chk("t1_run_wr_en", 32'(wr_en), 32'd1);
    chk("t1_run_addr", 32'(wr_addr), 32'd0);
    chk("t1_run_data", 32'(wr_data), 32'h43);
    step();
    rec_stop = 1'b1;
    step();
    chk("t1_busy", 32'(busy), 32'd1);
    rec_stop = 1'b0;
    step();
    chk("t1_flush_addr", 32'(wr_addr), 32'd1);
    chk("t1_flush_data", 32'(wr_data), 32'h02);
    step();
    chk("t1_mark_en", 32'(wr_en), 32'd1);
    chk("t1_mark_addr", 32'(wr_addr), 32'd2);
    chk("t1_mark_data", 32'(wr_data), 32'hC0);
    chk("t1_done_early", 32'(done), 32'd0);
    step();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_off", 32'(busy), 32'd0);
    chk("t1_wr_en_off", 32'(wr_en), 32'd0);
    chk("t1_entry", 32'(entry_count), 32'd3);
    chk("t1_full", 32'(full), 32'd0);
    chk("t1_ram0", 32'(ram[0]), 32'h43);
    chk("t1_ram1", 32'(ram[1]), 32'h02);
    chk("t1_ram2", 32'(ram[2]), 32'hC0);
    chk("t1_nwr", 32'(n_wr - w0), 32'd3);

    // TURN/lr1 held 40 cycles: saturated run splits
    w0 = n_wr;
    start_rec(2'b10, 1'b1);
    for (int i = 1; i < 40; i++) step();
    stop_and_finish();
    chk("t2_ram0", 32'(ram[0]), 32'hBF);
    chk("t2_ram1", 32'(ram[1]), 32'hA9);
    chk("t2_ram2", 32'(ram[2]), 32'hC0);
    chk("t2_nwr", 32'(n_wr - w0), 32'd3);
    chk("t2_entry", 32'(entry_count), 32'd3);

    // Toggling sample fills the RAM; re-armed from DONE
    w0 = n_wr;
    start_rec(2'b01, 1'b0);
    for (int i = 0; i < 14; i++) begin
      lr_in = ~lr_in;
      step();
    end
    chk("t3_full_set", 32'(full), 32'd1);
    chk("t3_last_rec_addr", 32'(wr_addr), 32'd13);
    step();
    step();
    step();
    chk("t3_ram0", 32'(ram[0]), 32'h41);
    chk("t3_ram1", 32'(ram[1]), 32'h61);
    chk("t3_ram13", 32'(ram[13]), 32'h61);
    chk("t3_ram14", 32'(ram[14]), 32'h41);
    chk("t3_ram15", 32'(ram[15]), 32'hC0);
    chk("t3_nwr", 32'(n_wr - w0), 32'd16);
    chk("t3_entry", 32'(entry_count), 32'd16);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_done", 32'(done), 32'd1);

    // state_in 11 is coerced to IDLE
    w0 = n_wr;
    start_rec(2'b11, 1'b0);
    step();
    step();
    step();
    stop_and_finish();
    chk("t4_ram0", 32'(ram[0]), 32'h04);
    chk("t4_ram1", 32'(ram[1]), 32'hC0);
    chk("t4_nwr", 32'(n_wr - w0), 32'd2);
    chk("t4_entry", 32'(entry_count), 32'd2);
    chk("t4_full_cleared", 32'(full), 32'd0);

    // Asynchronous reset right after a RECORD write
    start_rec(2'b10, 1'b0);
    state_in = 2'b01;
    step();
    chk("t5_pre_wr_en", 32'(wr_en), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_wr_en", 32'(wr_en), 32'd0);
    chk("t5_async_addr", 32'(wr_addr), 32'd0);
    chk("t5_async_data", 32'(wr_data), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_done", 32'(done), 32'd0);
    chk("t5_fsm_idle", 32'(dut.r_state), 32'(REC_IDLE));
    step();
    reset_n = 1'b1;
    step();
    start_rec(2'b00, 1'b0);
    state_in = 2'b01;
    lr_in    = 1'b1;
    step();
    chk("t5_restart_en", 32'(wr_en), 32'd1);
    chk("t5_restart_addr", 32'(wr_addr), 32'd0);
    chk("t5_restart_data", 32'(wr_data), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/turn_signal_recorder.md
# turn_signal_recorder

Captures the live turn-signal behaviour (controller state plus left/right select) into an external single-port RAM as a run-length-encoded sequence terminated by an end marker. It is the writer side of the memory playback path: the playback controller reads the same word format back and replays it. It sits between the live next-state/current-state logic and the RAM write port, clocked by the slow `memoryClock` tick.

## Interface
- `ADDR_W`, 4: RAM address width; depth `DEPTH = 2**ADDR_W`.
- `DUR_W`, 5: run-duration field width; `DUR_MAX = 2**DUR_W - 1`.
- `memoryClock` in 1: sample and write clock (slow tick).
- `reset_n` in 1: reset, asynchronous, active-low.
- `rec_start` in 1: level-sampled start request; acted on only in IDLE or DONE.
- `rec_stop` in 1: level-sampled stop request; acted on only in RECORD.
- `state_in` in 2: live controller state (00 IDLE, 01 HAZARD, 10 TURN).
- `lr_in` in 1: live left/right select (0 left, 1 right).
- `wr_en` out 1: RAM write strobe, one cycle per word.
- `wr_addr` out ADDR_W: RAM write address.
- `wr_data` out 3+DUR_W: word `{state[1:0], lr, dur[DUR_W-1:0]}`.
- `busy` out 1: high in RECORD, FLUSH, TERM.
- `full` out 1: recording ended by capacity; sticky until next start or reset.
- `done` out 1: high in DONE.
- `entry_count` out ADDR_W+1: words written, marker included; valid in DONE.

## Operation
- FSM states: IDLE, RECORD, FLUSH, TERM, DONE.
- Sample = `{state_in, lr_in}`; `state_in == 11` is coerced to 00 so the marker is never produced from live data.
- IDLE/DONE with `rec_start`: load `cur` = sample, `dur` = 1, `addr` = 0, clear `full` and `entry_count`, and go to RECORD.
- RECORD, each edge, in priority order:
  - `rec_stop`: go to FLUSH. The sample on that edge is discarded.
  - Sample ≠ `cur`, or `dur == DUR_MAX`: write `{cur, dur}` at `addr`, then `addr++`, `cur` = sample, `dur` = 1. If the new `addr == DEPTH-2`, set `full` and go to FLUSH.
  - Otherwise: `dur++`.
- FLUSH: write `{cur, dur}` at `addr`, then `addr++`, and go to TERM.
- TERM: write end marker `{2'b11, 1'b0, 0}` at `addr`, set `entry_count = addr+1`, and go to DONE.
- DONE: hold outputs. `rec_start` re-arms, and the next recording overwrites from address 0.
- `rec_start` in RECORD/FLUSH/TERM is ignored. `rec_stop` outside RECORD is ignored.
- A recording therefore always holds at least 2 words and at most DEPTH words.

## Timing
- All outputs are registered. `wr_en`, `wr_addr`, `wr_data` change together after the deciding edge and are held one cycle. The RAM commits the word on the following `memoryClock` edge.
- Latency: a run boundary seen at edge k puts the write on the bus after edge k.
- Stop at edge k: FLUSH word after edge k+1, marker after k+2, `done` after k+3.
- Reset at any time (including mid-write): FSM goes to IDLE immediately, with `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `full=0`, `done=0`, `entry_count=0`. A partial recording is left unterminated in the RAM.
- Durations count `memoryClock` cycles, so a saturated run splits into consecutive words with identical `{state, lr}`.

## Structure
- Shared package `turn_signal_pkg` holds:
  - the state encodings IDLE/HAZARD/TURN, shared with the live controller and playback;
  - the `END_MARK` state code 2'b11;
  - the word field layout;
  - the recorder FSM enum.
- No sub-module. The RAM is external, and the top level instantiates it alongside the playback ROM/RAM.

## Test plan
- Reset asserted with inputs active: all outputs 0 and `wr_en` never pulses.
- Start with HAZARD/lr0 for 3 cycles, then IDLE for 2, then `rec_stop`: words 0x43 @0, 0x02 @1, 0xC0 @2; `entry_count`=3; `full`=0.
- Start with TURN/lr1 held for 40 cycles, then stop: 0xBF @0, 0xA9 @1, 0xC0 @2.
- Sample toggles every cycle: 14 RECORD writes @0–13, FLUSH @14, marker @15; `full`=1; `entry_count`=16.
- `state_in`=11 held for 4 cycles, then stop: 0x04 @0, 0xC0 @1.
- `reset_n` low in the cycle after a RECORD write: `wr_en` drops asynchronously and the FSM is in IDLE. A subsequent start writes from address 0.
